perf_counter_uart_dump: RTL and testbench

//  Parametrised cache-performance counter bank with a UART dump engine. It counts N_EV

---
 rtl/perf_counter_uart_dump_pkg.sv | 32 +++
 rtl/perf_counter_uart_dump_uart_tx.sv | 101 ++++++++++
 rtl/perf_counter_uart_dump.sv | 156 +++++++++++++++
 tb/tb_perf_counter_uart_dump.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_uart_dump_pkg.sv
// Shared definitions for the cache performance counter dump block.
//   PERF_HDR_BYTE : default first byte of every dump frame
//   dump_state_e  : dump sequencer states (IDLE/LOAD/SEND/WAIT/FIN)
//   tx_state_e    : UART byte transmitter states (IDLE/START/DATA/STOP)
//   frame_len()   : number of bytes in one dump frame
package perf_pkg;

  localparam logic [7:0] PERF_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT,
    DUMP_FIN
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Header byte, CNT_W/8 bytes per channel, optional trailing checksum byte.
  function automatic int unsigned frame_len(input int unsigned n_ev,
                                            input int unsigned cnt_w,
                                            input bit          csum_en);
    return 32'd1 + n_ev * (cnt_w / 32'd8) + 32'(csum_en);
  endfunction

endpackage

// File: rtl/perf_counter_uart_dump_uart_tx.sv
// uart_tx_byte: 8N1 serialiser for a single byte.
//   clk, rstn : clock (rising edge), asynchronous active-low reset
//   start     : request to send byte_i; taken in IDLE, or on the final clock of
//               STOP so consecutive bytes run back-to-back with no idle bit
//   byte_i    : byte to send, LSB first
//   tx        : serial line, idles high, forced high by reset
//   busy      : transmitter is not idle
//   tx_done   : high on the final clock of the stop bit
// Parameter CLKS_PER_BIT (>= 2): clocks per bit.
module uart_tx_byte
  import perf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] byte_i,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e   state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end = (clk_cnt == BIT_LAST);
  assign busy    = (state != TX_IDLE);
  assign tx_done = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          tx      <= 1'b1;
          clk_cnt <= '0;
          if (start) begin
            shreg <= byte_i;
            tx    <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            state   <= TX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            // Chain straight into the next start bit when one is waiting.
            if (start) begin
              shreg <= byte_i;
              tx    <= 1'b0;
              state <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/perf_counter_uart_dump.sv
// perf_counter_uart_dump: saturating cache event counter bank with a UART dump.
// A rising edge on cpu_done (accepted only while idle) snapshots every counter
// and sends one 8N1 frame: HDR_BYTE, then each snapshot MSB byte first.
//   clk, rstn : clock (rising edge), asynchronous active-low reset
//   event_i   : per-channel event strobes, counted every clock they are high
//   cpu_done  : level; its rising edge requests a dump
//   cnt_clr   : synchronous clear of the live counters (wins over increments)
//   tx_data   : UART line, idles high
//   dump_busy : high from the accepted request until the last stop bit ends
//   dump_done : one-clock pulse after the last stop bit
// Optional build macro PERF_CSUM_EN appends one byte: XOR of all bytes after
// the header.
module perf_counter_uart_dump
  import perf_pkg::*;
#(
  parameter int         N_EV         = 8,
  parameter int         CNT_W        = 32,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HDR_BYTE     = PERF_HDR_BYTE
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_EV-1:0] event_i,
  input  logic            cpu_done,
  input  logic            cnt_clr,
  output logic            tx_data,
  output logic            dump_busy,
  output logic            dump_done
);

  localparam int BPC = CNT_W / 8;
`ifdef PERF_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int                FRAME_LEN = int'(frame_len(N_EV, CNT_W, CSUM_EN));
  localparam int                IDX_W     = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt  [N_EV];
  logic [CNT_W-1:0] snap [N_EV];
  logic             cpu_done_q;
  logic             done_rise;

  dump_state_e      dstate;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] sel;
  logic             last_byte;
  logic [7:0]       frame_bytes [2**IDX_W];
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done;

  assign done_rise = cpu_done & ~cpu_done_q;

  // Live counters: clear has priority, otherwise saturating increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_EV; k++) cnt[k] <= '0;
    end else if (cnt_clr) begin
      for (int k = 0; k < N_EV; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_EV; k++) begin
        if (event_i[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cpu_done_q <= 1'b0;
    else       cpu_done_q <= cpu_done;
  end

  // Frame image built from the snapshot; unused tail entries read as zero.
  always_comb begin
`ifdef PERF_CSUM_EN
    logic [7:0] csum;
    csum = '0;
`endif
    for (int i = 0; i < 2**IDX_W; i++) frame_bytes[i] = '0;
    frame_bytes[0] = HDR_BYTE;
    for (int k = 0; k < N_EV; k++) begin
      for (int b = 0; b < BPC; b++) begin
        frame_bytes[1 + k*BPC + b] = snap[k][CNT_W-1-8*b -: 8];
`ifdef PERF_CSUM_EN
        csum = csum ^ snap[k][CNT_W-1-8*b -: 8];
`endif
      end
    end
`ifdef PERF_CSUM_EN
    frame_bytes[FRAME_LEN-1] = csum;
`endif
  end

  // While waiting, the mux already points at the next byte so it can be handed
  // over on the transmitter's final stop-bit clock.
  assign last_byte = (byte_idx == LAST_IDX);
  assign sel       = (dstate == DUMP_WAIT) ? byte_idx + IDX_W'(1) : byte_idx;
  assign tx_start  = ((dstate == DUMP_SEND) && !tx_busy) ||
                     ((dstate == DUMP_WAIT) && tx_done && !last_byte);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dstate    <= DUMP_IDLE;
      byte_idx  <= '0;
      dump_busy <= 1'b0;
      dump_done <= 1'b0;
      for (int k = 0; k < N_EV; k++) snap[k] <= '0;
    end else begin
      case (dstate)
        DUMP_IDLE: begin
          if (done_rise) begin
            for (int k = 0; k < N_EV; k++) snap[k] <= cnt[k];
            byte_idx  <= '0;
            dump_busy <= 1'b1;
            dstate    <= DUMP_LOAD;
          end
        end
        DUMP_LOAD: dstate <= DUMP_SEND;
        // First byte starts here; later bytes were already chained from STOP.
        DUMP_SEND: dstate <= DUMP_WAIT;
        DUMP_WAIT: begin
          if (tx_done) begin
            if (last_byte) begin
              dump_busy <= 1'b0;
              dump_done <= 1'b1;
              dstate    <= DUMP_FIN;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              dstate   <= DUMP_SEND;
            end
          end
        end
        DUMP_FIN: begin
          dump_done <= 1'b0;
          dstate    <= DUMP_IDLE;
        end
        default: dstate <= DUMP_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rstn   (rstn),
    .start  (tx_start),
    .byte_i (frame_bytes[sel]),
    .tx     (tx_data),
    .busy   (tx_busy),
    .tx_done(tx_done)
  );

endmodule

// File: tb/tb_perf_counter_uart_dump.sv
// Directed bench for perf_counter_uart_dump (N_EV=8, CLKS_PER_BIT=4) with a
// 32-bit counter instance and an 8-bit counter instance sharing one UART monitor.
module tb_perf_counter_uart_dump;

`ifdef PERF_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [7:0] event_i;
  logic       cpu_done, cnt_clr;
  logic       tx_data, dump_busy, dump_done;
  logic [7:0] ev8;
  logic       cpu8, clr8;
  logic       tx8, busy8, done8;
  logic       mon_line;

  perf_counter_uart_dump #(.N_EV(8), .CNT_W(32), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .rstn(rstn), .event_i(event_i), .cpu_done(cpu_done), .cnt_clr(cnt_clr),
    .tx_data(tx_data), .dump_busy(dump_busy), .dump_done(dump_done));

  perf_counter_uart_dump #(.N_EV(8), .CNT_W(8), .CLKS_PER_BIT(4)) u_dut8 (
    .clk(clk), .rstn(rstn), .event_i(ev8), .cpu_done(cpu8), .cnt_clr(clr8),
    .tx_data(tx8), .dump_busy(busy8), .dump_done(done8));

  // Only one instance dumps at a time; both lines idle high.
  assign mon_line = tx_data & tx8;

  int          n_chk = 0, n_fail = 0;
  int          n_ferr = 0, rst_cnt = 0;
  int          busy_cyc, pulses, base, cyc, lows;
  logic [31:0] val;
  logic [7:0]  mon_q [$];
  logic [7:0]  exp_q [$];
  logic [63:0] ev_exp [8];

  always @(negedge rstn) rst_cnt++;

  // UART monitor: bit time 40 time units, sampled mid-bit on falling clock edges.
  initial begin : uart_mon
    logic [7:0] b;
    int         rc;
    logic       ok;
    @(posedge rstn);
    forever begin
      @(negedge mon_line);
      rc = rst_cnt;
      #25 ok = (mon_line == 1'b0);
      for (int i = 0; i < 8; i++) begin
        #40 b[i] = mon_line;
      end
      #40 ok = ok && (mon_line == 1'b1);
      if (rc == rst_cnt) begin
        mon_q.push_back(b);
        if (!ok) n_ferr++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame from hand-specified counter values.
  task automatic build_exp(input int bpc);
    logic [7:0] cs, by;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++) begin
      for (int b = bpc - 1; b >= 0; b--) begin
        by = 8'(ev_exp[k] >> (8 * b));
        exp_q.push_back(by);
        cs = cs ^ by;
      end
    end
    if (CS == 1) exp_q.push_back(cs);
  endtask

  task automatic check_frame(input string tag, input int from);
    chk({tag, " frame length"}, 64'(mon_q.size() - from), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (from + i < mon_q.size())
        chk($sformatf("%s byte%0d", tag, i), 64'(mon_q[from + i]), 64'(exp_q[i]));
    end
  endtask

  // Bounded wait for dump_done; keeps watching 20 clocks after it to catch extra pulses.
  task automatic wait_dump(input bit use8, input int limit, input string tag);
    int  c, post;
    bit  seen;
    c = 0; post = 0; seen = 1'b0;
    while (c < limit && !(seen && post >= 20)) begin
      @(negedge clk);
      c++;
      if (seen) post++;
      if (use8 ? busy8 : dump_busy) busy_cyc++;
      if (use8 ? done8 : dump_done) begin
        pulses++;
        seen = 1'b1;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin : stim
    rstn = 1'b0; event_i = '0; cpu_done = 1'b0; cnt_clr = 1'b0;
    ev8 = '0; cpu8 = 1'b0; clr8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_data", 64'(tx_data), 64'd1);
    chk("reset dump_busy", 64'(dump_busy), 64'd0);
    chk("reset dump_done", 64'(dump_done), 64'd0);
    chk("reset tx8", 64'(tx8), 64'd1);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ten events on ch0, three on ch2, then one dump with latency checks.
    event_i = 8'h01; repeat (10) @(negedge clk);
    event_i = 8'h04; repeat (3) @(negedge clk);
    event_i = 8'h00; @(negedge clk);
    base = mon_q.size(); busy_cyc = 0; pulses = 0;
    cpu_done = 1'b1;
    @(negedge clk);
    chk("s1 dump_busy one clk after rise", 64'(dump_busy), 64'd1);
    chk("s1 tx high at +1", 64'(tx_data), 64'd1);
    @(negedge clk);
    chk("s1 tx high at +2", 64'(tx_data), 64'd1);
    @(negedge clk);
    chk("s1 start bit at +3", 64'(tx_data), 64'd0);
    wait_dump(1'b0, 2000, "s1 dump completes");
    chk("s1 dump_done pulses", 64'(pulses), 64'd1);
    ev_exp = '{64'd10, 64'd0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    build_exp(4);
    check_frame("s1", base);

    // 2: cpu_done held high, extra rise mid-frame; exactly one frame.
    cpu_done = 1'b0; repeat (2) @(negedge clk);
    base = mon_q.size(); busy_cyc = 0; pulses = 0;
    cpu_done = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (dump_busy) busy_cyc++;
    end
    cpu_done = 1'b0;
    @(negedge clk);
    if (dump_busy) busy_cyc++;
    cpu_done = 1'b1;
    wait_dump(1'b0, 2000, "s2 dump completes");
    // LOAD and SEND clocks precede the first start bit, then 10 bits of 4 clocks per byte.
    chk("s2 dump_busy clocks", 64'(busy_cyc), 64'(2 + (33 + CS) * 10 * 4));
    chk("s2 dump_done pulses", 64'(pulses), 64'd1);
    check_frame("s2", base);
    repeat (200) @(negedge clk);
    chk("s2 no retrigger bytes", 64'(mon_q.size() - base), 64'(33 + CS));
    chk("s2 idle busy", 64'(dump_busy), 64'd0);

    // 3: 8-bit counters saturate at FF.
    ev8 = 8'h02; repeat (300) @(negedge clk);
    ev8 = 8'h00; @(negedge clk);
    base = mon_q.size(); busy_cyc = 0; pulses = 0;
    cpu8 = 1'b1;
    wait_dump(1'b1, 1000, "s3 dump completes");
    chk("s3 dump_done pulses", 64'(pulses), 64'd1);
    ev_exp = '{64'd0, 64'd255, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    build_exp(1);
    check_frame("s3", base);
    cpu8 = 1'b0;

    // 4: event held through the request; frame carries the accept-cycle value (5).
    cpu_done = 1'b0; cnt_clr = 1'b1; @(negedge clk);
    cnt_clr = 1'b0; event_i = 8'h01; repeat (5) @(negedge clk);
    base = mon_q.size(); busy_cyc = 0; pulses = 0;
    cpu_done = 1'b1;
    wait_dump(1'b0, 2000, "s4 dump completes");
    ev_exp = '{64'd5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    build_exp(4);
    check_frame("s4", base);
    cpu_done = 1'b0; @(negedge clk);
    base = mon_q.size(); pulses = 0;
    cpu_done = 1'b1;
    wait_dump(1'b0, 2000, "s4 second dump completes");
    val = '0;
    if (mon_q.size() >= base + 5) val = {mon_q[base+1], mon_q[base+2], mon_q[base+3], mon_q[base+4]};
    chk("s4 live counter kept rising", 64'(val > 32'd1320), 64'd1);

    // 5: clear and all events in the same cycle -> all counter bytes zero.
    cpu_done = 1'b0; cnt_clr = 1'b1; event_i = 8'hFF; @(negedge clk);
    cnt_clr = 1'b0; event_i = 8'h00; @(negedge clk);
    base = mon_q.size(); pulses = 0;
    cpu_done = 1'b1;
    wait_dump(1'b0, 2000, "s5 dump completes");
    ev_exp = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    build_exp(4);
    check_frame("s5", base);

    // 6: reset during byte 5, then a fresh full frame.
    cpu_done = 1'b0; event_i = 8'h08; repeat (7) @(negedge clk);
    event_i = 8'h00; @(negedge clk);
    base = mon_q.size();
    cpu_done = 1'b1;
    cyc = 0;
    while (mon_q.size() < base + 4 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("s6 four bytes before reset", 64'(mon_q.size() - base), 64'd4);
    repeat (3) @(negedge clk);
    rstn = 1'b0; cpu_done = 1'b0;
    #1;
    chk("s6 tx high on reset", 64'(tx_data), 64'd1);
    chk("s6 busy low on reset", 64'(dump_busy), 64'd0);
    chk("s6 done low on reset", 64'(dump_done), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    pulses = 0; lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (dump_done) pulses++;
      if (!tx_data) lows++;
    end
    chk("s6 no dump_done after abort", 64'(pulses), 64'd0);
    chk("s6 line idle after abort", 64'(lows), 64'd0);
    chk("s6 no resumed bytes", 64'(mon_q.size() - base), 64'd4);
    event_i = 8'h08; repeat (7) @(negedge clk);
    event_i = 8'h00; @(negedge clk);
    base = mon_q.size(); pulses = 0;
    cpu_done = 1'b1;
    wait_dump(1'b0, 2000, "s6 new dump completes");
    chk("s6 dump_done pulses", 64'(pulses), 64'd1);
    ev_exp = '{64'd0, 64'd0, 64'd0, 64'd7, 64'd0, 64'd0, 64'd0, 64'd0};
    build_exp(4);
    check_frame("s6", base);

    chk("framing errors", 64'(n_ferr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
